// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the fetch/execute memory sequencer.
package mem_seq_pkg;

   // Sequencer phases: instruction fetch, execute, optional load completion.
   typedef enum logic [1:0] {
      ST_FETCH,
      ST_EXEC,
      ST_MEM
   } state_t;

   // Instruction substituted when the PC points outside the RAM.
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   // All four byte lanes enabled; its width is the lane count of a word.
   localparam logic [3:0]  BE_ALL   = 4'hF;

endpackage

// File: rtl/sync_ram_be.sv
// Single-port synchronous RAM, 32-bit words with per-byte write enables.
// A read during a write to the same address returns the old word.
// READ_LAT=2 adds an output register after the array read.
module sync_ram_be
   import mem_seq_pkg::*;
#(
   parameter int DEPTH_WORDS = 4096,
   parameter int READ_LAT    = 1,
   localparam int AW         = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic [3:0]    we,
   input  logic [31:0]   wdata,
   output logic [31:0]   q
);

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] rd_q;

   // Array write per enabled lane, plus the registered read of the old word.
   // NOTE: the array has no reset; a RAM cannot be cleared in one cycle, so
   // contents are undefined until written and only the control path resets.
   always_ff @(posedge clk) begin
      for (int b = 0; b < $bits(BE_ALL); b++) begin
         if (we[b]) begin
            mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      rd_q <= mem[addr];
   end

   generate
      if (READ_LAT == 2) begin : g_out_reg
         logic [31:0] out_q;

         // Output register stage of a registered-output RAM.
         always_ff @(posedge clk) begin
            out_q <= rd_q;
         end

         assign q = out_q;
      end else begin : g_out_direct
         assign q = rd_q;
      end
   endgenerate

endmodule

// File: rtl/memory_sequencer.sv
// Fetch/execute sequencer around a unified instruction/data RAM.
// FETCH presents the PC for one issue cycle plus READ_LAT wait cycles and
// latches the instruction; EXEC performs a store or starts a load; MEM waits
// READ_LAT cycles for load data. Each commit loads next_pc and pulses retire.
module memory_sequencer
   import mem_seq_pkg::*;
#(
   parameter int          DEPTH_WORDS = 4096,
   parameter int          READ_LAT    = 1,
   parameter logic [31:0] RESET_PC    = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic [31:0] next_pc,
   input  logic [29:0] addr_in,
   input  logic [31:0] data_in,
   input  logic        S,
   input  logic        LD,
   input  logic [3:0]  be,
   output logic [31:0] I,
   output logic [31:0] PC,
   output logic [31:0] data_out,
   output logic        E,
   output logic        retire,
   output logic        addr_err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   // FETCH spends cnt 0 issuing the PC, then counts up to READ_LAT while the
   // RAM delivers; MEM's address was already issued in EXEC, so it only
   // waits cnt 0..READ_LAT-1.
   localparam logic [1:0] FETCH_LAST = 2'(READ_LAT);
   localparam logic [1:0] MEM_LAST   = 2'(READ_LAT - 1);

   state_t          state_q, state_d;
   logic [1:0]      cnt_q, cnt_d;
   logic [31:0]     pc_q;
   logic [31:0]     instr_q;
   logic [31:0]     dout_q;
   logic [AW-1:0]   addr_q;
   logic            retire_q;
   logic            err_q;

   logic [AW-1:0]   ram_addr;
   logic [3:0]      ram_we;
   logic [31:0]     ram_q;
   logic            commit;
   logic            err_set;
   logic            i_load;
   logic            d_load;
   logic            d_clear;
   logic            pc_oob;
   logic            data_oob;

   // Any address bit above the RAM index means the access falls off the end.
   assign pc_oob   = |pc_q[31:AW+2];
   assign data_oob = |addr_in[29:AW];

   // Next-state, RAM port control and commit decisions for the current phase.
   // NOTE: every output of this block gets a default before the case so no
   // path leaves a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ram_addr = pc_q[AW+1:2];
      ram_we   = 4'b0000;
      commit   = 1'b0;
      err_set  = 1'b0;
      i_load   = 1'b0;
      d_load   = 1'b0;
      d_clear  = 1'b0;

      case (state_q)
         ST_FETCH: begin
            ram_addr = pc_q[AW+1:2];
            if (!stall) begin
               if (cnt_q == FETCH_LAST) begin
                  cnt_d   = 2'd0;
                  i_load  = 1'b1;
                  err_set = pc_oob;
                  state_d = ST_EXEC;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end
         end

         ST_EXEC: begin
            ram_addr = addr_in[AW-1:0];
            if (!stall) begin
               if ((S || LD) && data_oob) begin
                  // Off-the-end access: drop it, zero the load data, retire.
                  err_set = 1'b1;
                  d_clear = 1'b1;
                  commit  = 1'b1;
                  state_d = ST_FETCH;
               end else if (S) begin
                  ram_we  = be;
                  commit  = 1'b1;
                  state_d = ST_FETCH;
               end else if (LD) begin
                  state_d = ST_MEM;
               end else begin
                  commit  = 1'b1;
                  state_d = ST_FETCH;
               end
            end
         end

         ST_MEM: begin
            ram_addr = addr_q;
            if (!stall) begin
               if (cnt_q == MEM_LAST) begin
                  cnt_d   = 2'd0;
                  d_load  = 1'b1;
                  commit  = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end
         end

         default: begin
            cnt_d   = 2'd0;
            state_d = ST_FETCH;
         end
      endcase

      // A store caught by reset is abandoned rather than half-completed.
      if (rst) begin
         ram_we = 4'b0000;
      end
   end

   // State, counter, PC and the registered outputs.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_FETCH;
         cnt_q    <= 2'd0;
         pc_q     <= RESET_PC;
         instr_q  <= NOP_WORD;
         dout_q   <= 32'h0;
         addr_q   <= '0;
         retire_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (commit) begin
            pc_q <= next_pc;
         end
         if (i_load) begin
            instr_q <= pc_oob ? NOP_WORD : ram_q;
         end
         if (d_load) begin
            dout_q <= ram_q;
         end else if (d_clear) begin
            dout_q <= 32'h0;
         end
         if (state_q == ST_EXEC && !stall) begin
            addr_q <= addr_in[AW-1:0];
         end
         retire_q <= commit;
         err_q    <= err_set;
      end
   end

   sync_ram_be #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .READ_LAT    (READ_LAT)
   ) u_ram (
      .clk   (clk),
      .addr  (ram_addr),
      .we    (ram_we),
      .wdata (data_in),
      .q     (ram_q)
   );

   assign I        = instr_q;
   assign PC       = pc_q;
   assign data_out = dout_q;
   assign E        = (state_q != ST_FETCH);
   assign retire   = retire_q;
   assign addr_err = err_q;

endmodule
